// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin arbitrating mux.
//   idx_w    : channel index width, clog2 with a floor of 1 so a 1-channel build still has a port
//   next_ptr : round-robin pointer advance with wrap N-1 -> 0
//   Rst*     : reset values of the output register and lock state
package rr_mux_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  localparam logic RstOutValid = 1'b0;
  localparam logic RstLock     = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
//   req       in  N_CH   request vector
//   ptr       in  IDX_W  highest-priority channel this cycle
//   grant     out N_CH   one-hot grant, zero when no request
//   grant_idx out IDX_W  binary index of the granted channel (0 when no grant)
module rr_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Walk ptr, ptr+1, ... modulo N_CH; the first requester found wins.
  always_comb begin
    int unsigned cand;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = (32'(ptr) + k) % N_CH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel, W-bit round-robin arbitrating mux with one registered output stage.
//   clk, rst_n : clock and synchronous active-low reset
//   in_valid / in_ready / in_data / in_last : per-channel valid/ready sources (flat data bus)
//   out_valid / out_ready / out_data / out_chan : registered output toward a single consumer
// Optional feature: define RR_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned IDX_W = idx_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_chan
);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_chan_q, out_chan_d;

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              can_load;
  logic              accept;

`ifdef RR_MUX_LOCK_EN
  logic lock_q, lock_d;

  // While locked, ptr_q names the owning channel and all other requests are masked.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      req[i] = in_valid[i] & (!lock_q || (ptr_q == IDX_W'(i)));
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign req         = in_valid;
`endif

  rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_load = !out_valid_q | out_ready;
  assign accept   = can_load & (|grant) & rst_n;
  assign in_ready = grant & {N_CH{can_load & rst_n}};

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
`ifdef RR_MUX_LOCK_EN
    lock_d      = lock_q;
`endif
    if (accept) begin
      // A drain in the same cycle is implicit: the register simply reloads.
      out_valid_d = 1'b1;
      out_data_d  = in_data[32'(grant_idx)*DATA_W +: DATA_W];
      out_chan_d  = grant_idx;
      ptr_d       = IDX_W'(next_ptr(32'(grant_idx), N_CH));
`ifdef RR_MUX_LOCK_EN
      if (!in_last[grant_idx]) begin
        lock_d = 1'b1;
        ptr_d  = grant_idx;
      end else begin
        lock_d = 1'b0;
      end
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= RstOutValid;
      out_data_q  <= '0;
      out_chan_q  <= '0;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= RstLock;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
